// File: rtl/encoder_decoder.sv
// ============================================================================
// encoder_decoder
// ----------------------------------------------------------------------------
// Purpose:
//   Decodes the debounced rotary-encoder A/B levels and the push key. It
//   produces one-cycle clockwise / counter-clockwise detent pulses, a bounded
//   selector value, and one-cycle short-press / long-press events.
//
// Parameters:
//   CLK_FRE  - clock frequency in Hz
//   LONG_MS  - long-press threshold in milliseconds
//   VAL_W    - width of o_value
//   MAX_VAL  - upper bound of o_value
//   INIT_VAL - reset value of o_value, and the value a long press restores
//   WRAP     - nonzero wraps MAX_VAL<->0; zero saturates at the bounds
//
// Ports:
//   i_clk       in   1      system clock, single domain
//   i_rst_n     in   1      synchronous active-low reset
//   i_enc_a     in   1      debounced encoder A, 1 = asserted
//   i_enc_b     in   1      debounced encoder B, 1 = asserted
//   i_enc_key   in   1      debounced push key, 1 = pressed
//   o_step_cw   out  1      one-cycle pulse per completed clockwise detent
//   o_step_ccw  out  1      one-cycle pulse per completed counter-clockwise detent
//   o_short     out  1      one-cycle pulse on release of a short press
//   o_long      out  1      one-cycle pulse when a press reaches the threshold
//   o_value     out  VAL_W  current selector value
// ============================================================================
module encoder_decoder #(
   parameter int CLK_FRE  = 50_000_000,
   parameter int LONG_MS  = 1000,
   parameter int VAL_W    = 8,
   parameter int MAX_VAL  = 255,
   parameter int INIT_VAL = 0,
   parameter int WRAP     = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enc_a,
   input  logic             i_enc_b,
   input  logic             i_enc_key,
   output logic             o_step_cw,
   output logic             o_step_ccw,
   output logic             o_short,
   output logic             o_long,
   output logic [VAL_W-1:0] o_value
);

   localparam logic [31:0]      LONG_CYC = 32'(CLK_FRE / 1000 * LONG_MS);
   localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
   localparam logic [VAL_W-1:0] INIT_V   = VAL_W'(INIT_VAL);
   localparam logic [VAL_W-1:0] ONE_V    = VAL_W'(1);

   // Each state implies the ab level it was entered on:
   // IDLE=00, CW1=10, CW2=11, CW3=01, CCW1=01, CCW2=11, CCW3=10.
   typedef enum logic [2:0] {
      IDLE,
      CW1,
      CW2,
      CW3,
      CCW1,
      CCW2,
      CCW3,
      ERR
   } quadState_t;

   quadState_t       r_state;
   quadState_t       w_nextState;
   logic [1:0]       w_ab;
   logic             w_stepCw;
   logic             w_stepCcw;
   logic             w_longHit;
   logic             w_shortHit;
   logic [VAL_W-1:0] w_valueNext;

   logic             r_stepCw;
   logic             r_stepCcw;
   logic             r_short;
   logic             r_long;
   logic [VAL_W-1:0] r_value;
   logic [31:0]      r_holdCnt;
   logic             r_armed;

   assign w_ab = {i_enc_a, i_enc_b};

   // Quadrature state register. Reset drops any partially turned detent.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Returning to 00 always lands in IDLE, whatever state
   // we were in. Otherwise each state accepts only the Gray-code neighbours
   // of its own ab level, and an ab equal to its own level holds the state.
   // Anything else is a double-bit jump and parks the decoder in ERR until
   // the encoder comes back to rest.
   always_comb begin
      w_nextState = r_state;
      if (w_ab == 2'b00) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ab == 2'b10) begin
                  w_nextState = CW1;
               end else if (w_ab == 2'b01) begin
                  w_nextState = CCW1;
               end else begin
                  w_nextState = ERR;
               end
            end
            CW1: begin
               if (w_ab == 2'b11) begin
                  w_nextState = CW2;
               end else if (w_ab == 2'b01) begin
                  w_nextState = ERR;
               end
            end
            CW2: begin
               if (w_ab == 2'b01) begin
                  w_nextState = CW3;
               end else if (w_ab == 2'b10) begin
                  w_nextState = CW1;
               end
            end
            CW3: begin
               if (w_ab == 2'b11) begin
                  w_nextState = CW2;
               end else if (w_ab == 2'b10) begin
                  w_nextState = ERR;
               end
            end
            CCW1: begin
               if (w_ab == 2'b11) begin
                  w_nextState = CCW2;
               end else if (w_ab == 2'b10) begin
                  w_nextState = ERR;
               end
            end
            CCW2: begin
               if (w_ab == 2'b10) begin
                  w_nextState = CCW3;
               end else if (w_ab == 2'b01) begin
                  w_nextState = CCW1;
               end
            end
            CCW3: begin
               if (w_ab == 2'b11) begin
                  w_nextState = CCW2;
               end else if (w_ab == 2'b01) begin
                  w_nextState = ERR;
               end
            end
            ERR: begin
               w_nextState = ERR;
            end
            default: begin
               w_nextState = ERR;
            end
         endcase
      end
   end

   // FSM outputs. A detent is complete only when the last phase of a full
   // rotation returns to 00; these strobes are registered below.
   always_comb begin
      w_stepCw  = (r_state == CW3)  && (w_ab == 2'b00);
      w_stepCcw = (r_state == CCW3) && (w_ab == 2'b00);
   end

   // Key classification. The hold counter saturates at the threshold, so it
   // passes LONG_CYC-1 exactly once per press and the long event cannot
   // repeat. A release finding the counter below the threshold means the
   // long event never fired for this press. Both events also need the
   // arming flag, so a key held across reset release is ignored.
   always_comb begin
      w_longHit  = r_armed && i_enc_key && (r_holdCnt == LONG_CYC - 32'd1);
      w_shortHit = r_armed && !i_enc_key && (r_holdCnt != 32'd0)
                   && (r_holdCnt < LONG_CYC);
   end

   // Selector value. A long press restores the initial value and wins over
   // a step completing in the same cycle. Steps either wrap or saturate at
   // the bounds.
   always_comb begin
      w_valueNext = r_value;
      if (w_longHit) begin
         w_valueNext = INIT_V;
      end else if (w_stepCw) begin
         if (r_value == MAX_V) begin
            w_valueNext = (WRAP != 0) ? '0 : MAX_V;
         end else begin
            w_valueNext = r_value + ONE_V;
         end
      end else if (w_stepCcw) begin
         if (r_value == '0) begin
            w_valueNext = (WRAP != 0) ? MAX_V : '0;
         end else begin
            w_valueNext = r_value - ONE_V;
         end
      end
   end

   // Registered outputs, value, hold counter and arming flag. The key is
   // armed the first time it is seen released after reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stepCw  <= 1'b0;
         r_stepCcw <= 1'b0;
         r_short   <= 1'b0;
         r_long    <= 1'b0;
         r_value   <= INIT_V;
         r_holdCnt <= 32'd0;
         r_armed   <= 1'b0;
      end else begin
         r_stepCw  <= w_stepCw;
         r_stepCcw <= w_stepCcw;
         r_short   <= w_shortHit;
         r_long    <= w_longHit;
         r_value   <= w_valueNext;
         if (!i_enc_key) begin
            r_holdCnt <= 32'd0;
            r_armed   <= 1'b1;
         end else if (r_holdCnt != LONG_CYC) begin
            r_holdCnt <= r_holdCnt + 32'd1;
         end
      end
   end

   assign o_step_cw  = r_stepCw;
   assign o_step_ccw = r_stepCcw;
   assign o_short    = r_short;
   assign o_long     = r_long;
   assign o_value    = r_value;

endmodule

// File: tb/tb_encoder_decoder.sv
// ============================================================================
// tb_encoder_decoder
// ----------------------------------------------------------------------------
// Self-checking bench for encoder_decoder with LONG_CYC=10, a value range of
// 0..9, an initial value of 5 and wrapping enabled. A behavioural model
// tracks the encoder as a signed displacement along the Gray cycle and the
// key as a press length. Each scenario task compares the DUT against that
// model every cycle and also checks the directed results it expects.
// ============================================================================
module tb_encoder_decoder;

   localparam int LONG_CYC = 10;
   localparam int MAX_VAL  = 9;
   localparam int INIT_VAL = 5;

   logic       clk = 1'b0;
   logic       rstN;
   logic       encA;
   logic       encB;
   logic       encKey;
   logic       stepCw;
   logic       stepCcw;
   logic       shortEv;
   logic       longEv;
   logic [3:0] value;

   int checks   = 0;
   int failures = 0;

   // Model state.
   int mD;
   bit mErr;
   int mPrevPos;
   int mValue;
   int mPress;
   bit mLongFired;
   bit mArmed;
   bit mPrevKey;
   bit eCw;
   bit eCcw;
   bit eShort;
   bit eLong;

   logic [1:0] cwSeq   [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] ccwSeq  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [1:0] grayAb  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int         wrapExp [3] = '{9, 0, 9};

   encoder_decoder #(
      .CLK_FRE  (1000),
      .LONG_MS  (10),
      .VAL_W    (4),
      .MAX_VAL  (MAX_VAL),
      .INIT_VAL (INIT_VAL),
      .WRAP     (1)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_enc_a    (encA),
      .i_enc_b    (encB),
      .i_enc_key  (encKey),
      .o_step_cw  (stepCw),
      .o_step_ccw (stepCcw),
      .o_short    (shortEv),
      .o_long     (longEv),
      .o_value    (value)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Position of an ab level along the clockwise Gray cycle.
   function automatic int grayPos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Reference model, advanced once per rising edge with the inputs that
   // edge samples. A detent counts when the encoder has moved three Gray steps
   // one way and then returns to rest; a two-step jump poisons the rotation
   // until rest.
   task automatic modelStep();
      int pos;
      int delta;
      eCw    = 1'b0;
      eCcw   = 1'b0;
      eShort = 1'b0;
      eLong  = 1'b0;
      if (!rstN) begin
         mD         = 0;
         mErr       = 1'b0;
         mPrevPos   = 0;
         mValue     = INIT_VAL;
         mPress     = 0;
         mLongFired = 1'b0;
         mArmed     = 1'b0;
         mPrevKey   = 1'b0;
      end else begin
         pos = grayPos({encA, encB});
         if (pos == 0) begin
            eCw  = !mErr && (mD == 3);
            eCcw = !mErr && (mD == -3);
            mD   = 0;
            mErr = 1'b0;
         end else if (!mErr) begin
            delta = (pos - mPrevPos + 4) % 4;
            if (delta == 1) begin
               mD++;
            end else if (delta == 3) begin
               mD--;
            end else if (delta == 2) begin
               mErr = 1'b1;
            end
         end
         mPrevPos = pos;
         if (encKey) begin
            mPress++;
            if (mArmed && (mPress == LONG_CYC)) begin
               eLong      = 1'b1;
               mLongFired = 1'b1;
            end
         end else begin
            if (mArmed && mPrevKey && !mLongFired) begin
               eShort = 1'b1;
            end
            mPress     = 0;
            mLongFired = 1'b0;
            mArmed     = 1'b1;
         end
         mPrevKey = encKey;
         if (eLong) begin
            mValue = INIT_VAL;
         end else if (eCw) begin
            mValue = (mValue + 1) % (MAX_VAL + 1);
         end else if (eCcw) begin
            mValue = (mValue + MAX_VAL) % (MAX_VAL + 1);
         end
      end
   endtask

   // One clock: advance the model on the edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] ab);
      {encA, encB} = ab;
   endtask

   task automatic test_reset();
      rstN   = 1'b0;
      encKey = 1'b0;
      applyStimulus(2'b00);
      repeat (3) tick();
      rstN = 1'b1;
      tick();
      checks++;
      if (value !== 4'd5) begin
         failures++;
         $display("FAIL reset_value got=%0d exp=5", value);
      end
      checks++;
      if ({stepCw, stepCcw, shortEv, longEv} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_pulses got=%b exp=0000", {stepCw, stepCcw, shortEv, longEv});
      end
   endtask

   task automatic test_cw_detents();
      int pulses = 0;
      for (int rep = 0; rep < 3; rep++) begin
         for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 3; c++) begin
               applyStimulus(cwSeq[ph]);
               tick();
               checks++;
               if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
                  failures++;
                  $display("FAIL cw_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
               end
               if (stepCw === 1'b1) begin
                  pulses++;
                  checks++;
                  if (value !== 4'(6 + rep)) begin
                     failures++;
                     $display("FAIL cw_value got=%0d exp=%0d", value, 6 + rep);
                  end
               end
            end
         end
      end
      checks++;
      if (pulses != 3) begin
         failures++;
         $display("FAIL cw_pulse_cycles got=%0d exp=3", pulses);
      end
   endtask

   task automatic test_wrap();
      int cwCount  = 0;
      int ccwCount = 0;
      for (int det = 0; det < 3; det++) begin
         for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 2; c++) begin
               applyStimulus((det < 2) ? cwSeq[ph] : ccwSeq[ph]);
               tick();
               checks++;
               if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
                  failures++;
                  $display("FAIL wrap_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
               end
               if (stepCw === 1'b1 || stepCcw === 1'b1) begin
                  if (stepCw === 1'b1) cwCount++;
                  if (stepCcw === 1'b1) ccwCount++;
                  checks++;
                  if (value !== 4'(wrapExp[det])) begin
                     failures++;
                     $display("FAIL wrap_value got=%0d exp=%0d", value, wrapExp[det]);
                  end
               end
            end
         end
      end
      checks++;
      if (cwCount != 2 || ccwCount != 1) begin
         failures++;
         $display("FAIL wrap_counts got=cw%0d_ccw%0d exp=cw2_ccw1", cwCount, ccwCount);
      end
   endtask

   task automatic test_partial_and_err();
      logic [1:0] seq [10] = '{2'b10, 2'b11, 2'b10, 2'b00,
                               2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
      int stepSeen = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 2; c++) begin
            applyStimulus(seq[i]);
            tick();
            checks++;
            if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
               failures++;
               $display("FAIL partial_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
            end
            if (stepCw === 1'b1 || stepCcw === 1'b1) stepSeen++;
         end
      end
      checks++;
      if (stepSeen != 0 || value !== 4'd9) begin
         failures++;
         $display("FAIL partial_no_step got=steps%0d_val%0d exp=steps0_val9", stepSeen, value);
      end
   endtask

   task automatic test_key_press();
      int shorts = 0;
      int longs  = 0;
      int len    [2] = '{4, 15};
      for (int p = 0; p < 2; p++) begin
         for (int k = 1; k <= len[p] + 3; k++) begin
            encKey = (k <= len[p]);
            tick();
            checks++;
            if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
               failures++;
               $display("FAIL key_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
            end
            if (shortEv === 1'b1) shorts++;
            if (longEv === 1'b1) longs++;
            if (p == 0 && k == len[p] + 1) begin
               checks++;
               if (shortEv !== 1'b1) begin
                  failures++;
                  $display("FAIL short_on_release got=%b exp=1", shortEv);
               end
            end
            if (p == 1 && k == LONG_CYC) begin
               checks++;
               if (longEv !== 1'b1 || value !== 4'd5) begin
                  failures++;
                  $display("FAIL long_at_10 got=long%b_val%0d exp=long1_val5", longEv, value);
               end
            end
         end
      end
      checks++;
      if (shorts != 1 || longs != 1) begin
         failures++;
         $display("FAIL key_counts got=s%0d_l%0d exp=s1_l1", shorts, longs);
      end
   endtask

   task automatic test_reset_held_key();
      int events = 0;
      int shorts = 0;
      encKey = 1'b1;
      rstN   = 1'b0;
      repeat (3) tick();
      rstN = 1'b1;
      for (int k = 0; k < 23; k++) begin
         encKey = (k < 20);
         tick();
         checks++;
         if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
            failures++;
            $display("FAIL held_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
         end
         if (shortEv === 1'b1 || longEv === 1'b1) events++;
      end
      checks++;
      if (events != 0) begin
         failures++;
         $display("FAIL held_through_reset got=%0d exp=0", events);
      end
      for (int k = 0; k < 7; k++) begin
         encKey = (k < 4);
         tick();
         if (shortEv === 1'b1) shorts++;
      end
      checks++;
      if (shorts != 1) begin
         failures++;
         $display("FAIL rearmed_short got=%0d exp=1", shorts);
      end
   endtask

   task automatic test_step_long_collision();
      logic [1:0] abAt [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      encKey = 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
         applyStimulus(cwSeq[ph]);
         tick();
      end
      tick();
      for (int k = 1; k <= 13; k++) begin
         encKey = (k <= 10);
         applyStimulus((k <= 10) ? abAt[k-1] : 2'b00);
         tick();
         checks++;
         if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
            failures++;
            $display("FAIL collide_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
         end
         if (k == 10) begin
            checks++;
            if ({stepCw, longEv} !== 2'b11 || value !== 4'd5) begin
               failures++;
               $display("FAIL collide_clear got=cw%b_long%b_val%0d exp=cw1_long1_val5", stepCw, longEv, value);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int cwCount  = 0;
      int ccwCount = 0;
      for (int det = 0; det < 7; det++) begin
         for (int ph = 0; ph < 4; ph++) begin
            applyStimulus((det < 4) ? cwSeq[ph] : ccwSeq[ph]);
            tick();
            checks++;
            if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
               failures++;
               $display("FAIL b2b_model got=%b_%0d exp=%b_%0d", {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
            end
            if (stepCw === 1'b1) cwCount++;
            if (stepCcw === 1'b1) ccwCount++;
         end
      end
      tick();
      if (stepCcw === 1'b1) ccwCount++;
      checks++;
      if (cwCount != 4 || ccwCount != 3 || value !== 4'd6) begin
         failures++;
         $display("FAIL b2b_totals got=cw%0d_ccw%0d_val%0d exp=cw4_ccw3_val6", cwCount, ccwCount, value);
      end
   endtask

   task automatic test_random();
      int pos     = 0;
      int dir     = 1;
      int keyRun  = 0;
      int r;
      for (int i = 0; i < 3000; i++) begin
         if (i % 40 == 0) dir = ($urandom_range(0, 1) == 0) ? 1 : -1;
         r = int'($urandom_range(0, 19));
         if (r < 6) begin
            pos = pos;
         end else if (r < 14) begin
            pos = (pos + dir + 4) % 4;
         end else if (r < 17) begin
            pos = (pos - dir + 4) % 4;
         end else if (r < 18) begin
            pos = 0;
         end else if (r < 19) begin
            pos = int'($urandom_range(0, 3));
         end
         applyStimulus(grayAb[pos]);
         if (keyRun == 0) begin
            encKey = !encKey;
            keyRun = encKey ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 6));
         end
         keyRun--;
         rstN = ($urandom_range(0, 299) != 0);
         tick();
         checks++;
         if ({stepCw, stepCcw, shortEv, longEv, value} !== {eCw, eCcw, eShort, eLong, 4'(mValue)}) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%b_%0d exp=%b_%0d", i, {stepCw, stepCcw, shortEv, longEv}, value, {eCw, eCcw, eShort, eLong}, mValue);
         end
      end
      rstN = 1'b1;
   endtask

   // Scenario sequence; each scenario starts from where the previous left
   // the selector value.
   initial begin
      rstN   = 1'b0;
      encA   = 1'b0;
      encB   = 1'b0;
      encKey = 1'b0;
      $display("[TB] encoder_decoder bench start");
      test_reset();
      test_cw_detents();
      test_wrap();
      test_partial_and_err();
      test_key_press();
      test_reset_held_key();
      test_step_long_collision();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/encoder_decoder.md
# encoder_decoder

Rotary-encoder decoder sitting directly downstream of the three `Encoder_filter` instances (A, B, push-key) on the LCD bittest board. Consumes debounced, asserted-high encoder levels. Produces:
- one-cycle CW/CCW step pulses and a bounded value register for the menu/pattern selector;
- one-cycle short-press and long-press events from the push key.

## Interface
- `CLK_FRE`, 50_000_000: clock frequency in Hz.
- `LONG_MS`, 1000: long-press threshold in ms. `LONG_CYC = CLK_FRE/1000*LONG_MS`, computed in 32 bits.
- `VAL_W`, 8: width of `o_value`.
- `MAX_VAL`, 255: upper bound of `o_value`, where `MAX_VAL < 2**VAL_W`.
- `INIT_VAL`, 0: reset and clear value of `o_value`, where `INIT_VAL <= MAX_VAL`.
- `WRAP`, 1: 1 means wrap `MAX_VAL↔0`; 0 means saturate at the bounds.

Ports:
- `i_clk  in  1`: system clock. Single clock domain.
- `i_rst_n  in  1`: synchronous, active-low reset.
- `i_enc_a  in  1`: debounced encoder A, 1 = asserted.
- `i_enc_b  in  1`: debounced encoder B, 1 = asserted.
- `i_enc_key  in  1`: debounced push key, 1 = pressed.
- `o_step_cw  out  1`: one-cycle pulse per completed clockwise detent.
- `o_step_ccw  out  1`: one-cycle pulse per completed counter-clockwise detent.
- `o_short  out  1`: one-cycle pulse on release of a press shorter than `LONG_CYC` cycles.
- `o_long  out  1`: one-cycle pulse when a press reaches `LONG_CYC` cycles.
- `o_value  out  VAL_W`: current selector value.

## Operation
- All inputs come from registered upstream logic in the same domain. There is no extra synchronizer.
- Quadrature FSM states: `IDLE`, `CW1`, `CW2`, `CW3`, `CCW1`, `CCW2`, `CCW3`, `ERR`. Let ab = {`i_enc_a`, `i_enc_b`}.
- From `IDLE`:
  - ab=10 goes to `CW1`;
  - ab=01 goes to `CCW1`;
  - ab=11 goes to `ERR`.
- Clockwise path:
  - `CW1`: ab=11 goes to `CW2`.
  - `CW2`: ab=01 goes to `CW3`; ab=10 goes back to `CW1`.
  - `CW3`: ab=00 goes to `IDLE` and fires `o_step_cw`; ab=11 goes back to `CW2`.
- Counter-clockwise path mirrors the clockwise path with a/b swapped: `CCW1` then 11 gives `CCW2`, then 10 gives `CCW3`, then 00 fires `o_step_ccw`.
- Any state, ab=00 without completing a detent: goes to `IDLE` with no pulse.
- Any other transition (a double-bit jump, or an undefined move) goes to `ERR`.
- `ERR` stays until ab=00, then goes to `IDLE` with no pulse.
- An unchanged ab holds the current state.

Value register:
- CW increments `o_value` and CCW decrements it.
- At `MAX_VAL`+CW, the result is 0 if `WRAP`=1, else it holds at `MAX_VAL`.
- At 0+CCW, the result is `MAX_VAL` if `WRAP`=1, else it holds at 0.

Key handling:
- `hold_cnt` is 32 bits, cleared while the key = 0.
- `hold_cnt` increments each cycle the key = 1 and saturates at `LONG_CYC`.
- `o_long` fires once, when `hold_cnt` becomes `LONG_CYC`. This also clears `o_value` to `INIT_VAL`.
- `o_short` fires on a 1→0 key transition if `o_long` has not fired for this press.
- Release after a long press produces nothing.
- Arming flag:
  - after reset, the key must be seen at 0 at least once before presses are classified;
  - a key held through reset release produces no event.
- Simultaneous step and long press in the same cycle: both pulses assert, and the clear to `INIT_VAL` takes priority over the step.

## Timing
Reset (`i_rst_n`=0 at a rising edge):
- FSM goes to `IDLE`;
- all pulses are 0;
- `o_value` = `INIT_VAL`;
- `hold_cnt` = 0;
- arming flag = 0.
Reset mid-rotation or mid-press discards the partial detent or press.

Latency and pulse shape:
- All outputs are registered.
- A step pulse is high for exactly one cycle, starting the cycle after the edge that samples ab=00 in `CW3`/`CCW3`.
- `o_value` updates at that same edge, so the new value is visible concurrently with the pulse.
- `o_long` is high in the cycle after the `LONG_CYC`-th consecutive sampled key=1.
- `o_short` is high in the cycle after the first sampled key=0.

Sustained rotation: back-to-back detents with one cycle per ab phase are supported, giving a minimum of 4 cycles per step.

## Test plan
Bench parameters: `CLK_FRE`=1000, `LONG_MS`=10 (`LONG_CYC`=10), `VAL_W`=4, `MAX_VAL`=9, `INIT_VAL`=5, `WRAP`=1.
- **Reset:** hold `i_rst_n`=0 for 3 cycles, then release → `o_value`=5, all pulses 0.
- **CW detents:** ab 00→10→11→01→00, each held 3 cycles, done three times → three `o_step_cw` pulses, each exactly 1 cycle; `o_value` goes 6, 7, 8.
- **Wrap:** from 8, two CW detents → `o_value` 9 then 0. A CCW detent (00→01→11→10→00) → `o_value` 9.
- **Partial detent and illegal jump:**
  - 00→10→11→10→00 → no pulse, value unchanged;
  - 00→11 → FSM in `ERR`, stays there while ab=11 or 10, no pulse until 00.
- **Key presses:**
  - press for 4 cycles → one `o_short` pulse on release, no `o_long`;
  - press for 15 cycles → `o_long` after the 10th pressed cycle, `o_value`=5, and no `o_short` on release.
- **Reset during a held key:** key=1 through reset release, held 20 cycles, then released → no `o_long`, no `o_short`. The next 4-cycle press → `o_short`.
